// File: rtl/fractal_sync_pkg.sv
// Shared response types and default widths for the fractal sync tree.
// Input dst carries one routing bit per port below the forwarded dst bits.
package fractal_sync_pkg;

    localparam int unsigned IN_DST_W    = 6;
    localparam int unsigned OUT_DST_W   = 4;
    localparam int unsigned DEF_N_PORTS = 2;

    typedef struct packed {
        logic                wake;
        logic [IN_DST_W-1:0] dst;
        logic                error;
    } fsync_rsp_in_t;

    typedef struct packed {
        logic                 wake;
        logic [OUT_DST_W-1:0] dst;
        logic                 error;
    } fsync_rsp_out_t;

endpackage

// File: rtl/fractal_sync_fifo.sv
// Small synchronous FIFO with combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fractal_sync_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter type         data_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  data_t                        data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output data_t                        data_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    import fractal_sync_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [LVL_W-1:0] r_cnt;
    data_t            r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == LVL_W'(DEPTH));
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            if (w_push && !w_pop)      r_cnt <= r_cnt + LVL_W'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - LVL_W'(1);
        end
    end

    // Storage is not reset; the empty gate on data_o hides stale entries.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end

    assign valid_o = ~w_empty;
    assign data_o  = w_empty ? '0 : r_mem[r_rd];
    assign full_o  = w_full;
    assign level_o = r_cnt;

endmodule

// File: rtl/fractal_sync_mp_tx.sv
// Multi-port sync response transmitter: fans one response out to per-port
// FIFOs selected by the low dst bits, with sticky overflow and drop counters.
module fractal_sync_mp_tx #(
    parameter type fsync_rsp_in_t  = fractal_sync_pkg::fsync_rsp_in_t,
    parameter type fsync_rsp_out_t = fractal_sync_pkg::fsync_rsp_out_t,
    parameter int unsigned N_PORTS    = fractal_sync_pkg::DEF_N_PORTS,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          COMB_IN    = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  fsync_rsp_in_t                                 rsp_i,
    input  logic                                          clear_i,
    output logic           [N_PORTS-1:0]                  valid_o,
    output fsync_rsp_out_t [N_PORTS-1:0]                  rsp_o,
    input  logic           [N_PORTS-1:0]                  ready_i,
    output logic [N_PORTS-1:0][$clog2(FIFO_DEPTH+1)-1:0]  level_o,
    output logic           [N_PORTS-1:0]                  overflow_o,
    output logic [N_PORTS-1:0][CNT_W-1:0]                 drop_cnt_o
);
    import fractal_sync_pkg::*;

    // wake and error are single bits; the rest of each struct is dst.
    localparam int unsigned IN_DW  = $bits(fsync_rsp_in_t) - 2;
    localparam int unsigned OUT_DW = $bits(fsync_rsp_out_t) - 2;

    if (FIFO_DEPTH == 0 || N_PORTS == 0 || OUT_DW + N_PORTS != IN_DW)
    begin : g_param_err
        $error("fractal_sync_mp_tx: bad FIFO_DEPTH, N_PORTS or dst widths");
    end

    fsync_rsp_out_t     w_pay_d;
    fsync_rsp_out_t     w_pay;
    logic [N_PORTS-1:0] w_push_d;
    logic [N_PORTS-1:0] w_push;
    logic [N_PORTS-1:0] w_pop;
    logic [N_PORTS-1:0] w_full;
    logic [N_PORTS-1:0] w_drop;

    always_comb begin
        w_pay_d       = '0;
        w_pay_d.wake  = rsp_i.wake;
        w_pay_d.error = rsp_i.error;
        w_pay_d.dst   = OUT_DW'(rsp_i.dst >> N_PORTS);
        for (int p = 0; p < N_PORTS; p++) begin
            w_push_d[p] = rsp_i.wake & rsp_i.dst[p];
        end
    end

    if (COMB_IN) begin : g_comb_in
        assign w_pay  = w_pay_d;
        assign w_push = w_push_d;
    end else begin : g_reg_in
        fsync_rsp_out_t     r_pay;
        logic [N_PORTS-1:0] r_push;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pay  <= '0;
                r_push <= '0;
            end else begin
                if (rsp_i.wake) r_pay <= w_pay_d;
                r_push <= w_push_d;
            end
        end

        assign w_pay  = r_pay;
        assign w_push = r_push;
    end

    assign w_pop  = ready_i & valid_o;
    assign w_drop = w_push & w_full & ~w_pop;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic             r_ov;
        logic [CNT_W-1:0] r_cnt;

        fractal_sync_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .data_t (fsync_rsp_out_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (w_push[p]),
            .data_i  (w_pay),
            .pop_i   (ready_i[p]),
            .valid_o (valid_o[p]),
            .data_o  (rsp_o[p]),
            .full_o  (w_full[p]),
            .level_o (level_o[p])
        );

        // A drop in the clearing cycle still counts as the first new drop.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ov  <= 1'b0;
                r_cnt <= '0;
            end else if (clear_i) begin
                r_ov  <= w_drop[p];
                r_cnt <= w_drop[p] ? CNT_W'(1) : '0;
            end else if (w_drop[p]) begin
                r_ov <= 1'b1;
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign overflow_o[p] = r_ov;
        assign drop_cnt_o[p] = r_cnt;
    end

endmodule

// File: tb/tb_fractal_sync_mp_tx.sv
// Bench for fractal_sync_mp_tx: directed vector table plus random traffic
// checked against a queue-based reference model.
module tb_fractal_sync_mp_tx;
    import fractal_sync_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    fsync_rsp_in_t        rsp_i;
    logic                 clear_i;
    logic [1:0]           valid_o;
    fsync_rsp_out_t [1:0] rsp_o;
    logic [1:0]           ready_i;
    logic [1:0][1:0]      level_o;
    logic [1:0]           overflow_o;
    logic [1:0][7:0]      drop_cnt_o;

    always #5 clk_i = ~clk_i;

    fractal_sync_mp_tx #(
        .N_PORTS    (2),
        .FIFO_DEPTH (2),
        .COMB_IN    (1'b0),
        .CNT_W      (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rsp_i      (rsp_i),
        .clear_i    (clear_i),
        .valid_o    (valid_o),
        .rsp_o      (rsp_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    typedef struct {
        logic [1:0] rdy;
        logic       clr;
        logic       wk;
        logic [5:0] dst;
        logic       err;
        logic [1:0] e_vld;
        int         e_l0;
        int         e_l1;
        logic [1:0] e_ov;
        int         e_c0;
        int         e_c1;
        logic [3:0] e_hd0;
    } vec_t;

    function automatic vec_t mk(logic [1:0] rdy, logic clr, logic wk,
                                logic [5:0] dst, logic err, logic [1:0] v,
                                int l0, int l1, logic [1:0] ov, int c0,
                                int c1, logic [3:0] hd);
        vec_t t;
        t.rdy = rdy; t.clr = clr; t.wk = wk; t.dst = dst; t.err = err;
        t.e_vld = v; t.e_l0 = l0; t.e_l1 = l1; t.e_ov = ov;
        t.e_c0 = c0; t.e_c1 = c1; t.e_hd0 = hd;
        return t;
    endfunction

    task automatic drive(logic [1:0] rdy, logic clr, logic wk,
                         logic [5:0] dst, logic err);
        ready_i     = rdy;
        clear_i     = clr;
        rsp_i.wake  = wk;
        rsp_i.dst   = dst;
        rsp_i.error = err;
    endtask

    // Reference model: each port is a queue; a response sampled in one cycle
    // reaches the queues on the following edge.
    logic [5:0] mq [2][$];
    logic       m_ov  [2];
    int         m_cnt [2];
    logic       m_pw;
    logic [1:0] m_pdst;
    logic [5:0] m_pay;

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            mq[p].delete();
            m_ov[p]  = 1'b0;
            m_cnt[p] = 0;
        end
        m_pw   = 1'b0;
        m_pdst = '0;
        m_pay  = '0;
    endtask

    task automatic m_step();
        for (int p = 0; p < 2; p++) begin
            bit pp, ps, dr;
            pp = ready_i[p] && (mq[p].size() > 0);
            ps = m_pw && m_pdst[p];
            dr = ps && (mq[p].size() == 2) && !pp;
            if (pp) void'(mq[p].pop_front());
            if (ps && !dr) mq[p].push_back(m_pay);
            if (clear_i) begin
                m_ov[p]  = dr;
                m_cnt[p] = dr ? 1 : 0;
            end else if (dr) begin
                m_ov[p] = 1'b1;
                if (m_cnt[p] < 255) m_cnt[p]++;
            end
        end
        m_pw = rsp_i.wake;
        if (rsp_i.wake) begin
            m_pdst = rsp_i.dst[1:0];
            m_pay  = {1'b1, rsp_i.dst[5:2], rsp_i.error};
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 0);
        chk({tag, "_rsp"},   32'(rsp_o), 0);
        chk({tag, "_level"}, 32'(level_o), 0);
        chk({tag, "_ovf"},   32'(overflow_o), 0);
        chk({tag, "_drops"}, 32'(drop_cnt_o), 0);
    endtask

    vec_t tv [29];

    initial begin
        tv[0]  = mk(2'b00,0,1,6'b000101,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[1]  = mk(2'b00,0,0,6'b000000,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[2]  = mk(2'b01,0,0,6'b000000,0, 2'b01,1,0,2'b00,0,0,4'h1);
        tv[3]  = mk(2'b00,0,0,6'b000000,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[4]  = mk(2'b00,0,1,6'b000011,1, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[5]  = mk(2'b00,0,0,6'b000000,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[6]  = mk(2'b01,0,0,6'b000000,0, 2'b11,1,1,2'b00,0,0,4'h0);
        tv[7]  = mk(2'b10,0,0,6'b000000,0, 2'b10,0,1,2'b00,0,0,4'h0);
        tv[8]  = mk(2'b00,0,0,6'b000000,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[9]  = mk(2'b00,0,1,6'b000101,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[10] = mk(2'b00,0,1,6'b001001,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[11] = mk(2'b00,0,1,6'b001101,0, 2'b01,1,0,2'b00,0,0,4'h1);
        tv[12] = mk(2'b00,0,0,6'b000000,0, 2'b01,2,0,2'b00,0,0,4'h1);
        tv[13] = mk(2'b01,0,0,6'b000000,0, 2'b01,2,0,2'b01,1,0,4'h1);
        tv[14] = mk(2'b01,0,0,6'b000000,0, 2'b01,1,0,2'b01,1,0,4'h2);
        tv[15] = mk(2'b00,1,0,6'b000000,0, 2'b00,0,0,2'b01,1,0,4'h0);
        tv[16] = mk(2'b00,0,1,6'b000101,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[17] = mk(2'b00,0,1,6'b001001,0, 2'b00,0,0,2'b00,0,0,4'h0);
        tv[18] = mk(2'b00,0,1,6'b001101,0, 2'b01,1,0,2'b00,0,0,4'h1);
        tv[19] = mk(2'b01,0,0,6'b000000,0, 2'b01,2,0,2'b00,0,0,4'h1);
        tv[20] = mk(2'b00,0,0,6'b000000,0, 2'b01,2,0,2'b00,0,0,4'h2);
        tv[21] = mk(2'b00,0,1,6'b000001,0, 2'b01,2,0,2'b00,0,0,4'h2);
        tv[22] = mk(2'b00,0,1,6'b000001,0, 2'b01,2,0,2'b00,0,0,4'h2);
        tv[23] = mk(2'b00,0,1,6'b000001,0, 2'b01,2,0,2'b01,1,0,4'h2);
        tv[24] = mk(2'b00,0,0,6'b000000,0, 2'b01,2,0,2'b01,2,0,4'h2);
        tv[25] = mk(2'b00,1,0,6'b000000,0, 2'b01,2,0,2'b01,3,0,4'h2);
        tv[26] = mk(2'b00,0,1,6'b000001,0, 2'b01,2,0,2'b00,0,0,4'h2);
        tv[27] = mk(2'b00,1,0,6'b000000,0, 2'b01,2,0,2'b00,0,0,4'h2);
        tv[28] = mk(2'b00,0,0,6'b000000,0, 2'b01,2,0,2'b01,1,0,4'h2);

        rst_ni = 1'b0;
        drive(2'b00, 0, 0, 6'b0, 0);
        #12;
        chk_reset_outs("in_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk_i);
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tv[i].e_vld));
            chk($sformatf("v%0d_lvl0", i), 32'(level_o[0]), tv[i].e_l0);
            chk($sformatf("v%0d_lvl1", i), 32'(level_o[1]), tv[i].e_l1);
            chk($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(tv[i].e_ov));
            chk($sformatf("v%0d_cnt0", i), 32'(drop_cnt_o[0]), tv[i].e_c0);
            chk($sformatf("v%0d_cnt1", i), 32'(drop_cnt_o[1]), tv[i].e_c1);
            chk($sformatf("v%0d_dst0", i), 32'(rsp_o[0].dst),
                32'(tv[i].e_hd0));
            if (i == 6) begin
                chk("dual_err0", 32'(rsp_o[0].error), 1);
                chk("dual_err1", 32'(rsp_o[1].error), 1);
                chk("dual_dst1", 32'(rsp_o[1].dst), 0);
            end
            drive(tv[i].rdy, tv[i].clr, tv[i].wk, tv[i].dst, tv[i].err);
        end

        // Fresh reset, then random traffic against the model.
        @(negedge clk_i);
        drive(2'b00, 0, 0, 6'b0, 0);
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("rst_async");
        m_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            for (int p = 0; p < 2; p++) begin
                logic [5:0] a, e;
                a = rsp_o[p];
                e = (mq[p].size() > 0) ? mq[p][0] : 6'b0;
                chk($sformatf("r%0d_p%0d_valid", c, p), 32'(valid_o[p]),
                    32'(mq[p].size() > 0));
                chk($sformatf("r%0d_p%0d_rsp", c, p), 32'(a), 32'(e));
                chk($sformatf("r%0d_p%0d_lvl", c, p), 32'(level_o[p]),
                    mq[p].size());
                chk($sformatf("r%0d_p%0d_ovf", c, p), 32'(overflow_o[p]),
                    32'(m_ov[p]));
                chk($sformatf("r%0d_p%0d_cnt", c, p), 32'(drop_cnt_o[p]),
                    m_cnt[p]);
            end
            drive(2'($urandom_range(0, 3) & $urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  6'($urandom),
                  1'($urandom));
            @(posedge clk_i);
            m_step();
        end

        // Reset asserted mid-operation must clear everything at once.
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("rst_midop");
        drive(2'b00, 0, 0, 6'b0, 0);
        @(negedge clk_i);
        chk_reset_outs("rst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
